// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, then shifts one byte plus
// odd parity and stop out on device-generated clock edges and checks the device ACK.
//
// state     | meaning
// IDLE      | lines released, ready to accept a byte
// INHIBIT   | PS2Clk held low; start bit asserted in the final cycle
// RELEASE   | clock released, start bit held, waiting for first device edge
// SHIFT     | driving d0..d7, parity, stop on device falling edges 1..10
// ACK       | waiting for edge 11 to sample the device ACK
// WAIT_IDLE | waiting for both lines to return high
// ERR       | lines released, reporting timeout

module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_f
);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          s1;
  logic          s2;
  logic [FW-1:0] cnt;

  // Counter tracks consecutive samples that differ from the accepted level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      cnt    <= '0;
      line_f <= 1'b1;
    end else begin
      s1 <= line_in;
      s2 <= s1;
      if (s2 == line_f) begin
        cnt <= '0;
      end else if (cnt == FW'(FILTER_LEN - 1)) begin
        line_f <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + FW'(1);
      end
    end
  end
endmodule

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 9450,
  parameter int START_TIMEOUT  = 1417500,
  parameter int XFER_TIMEOUT   = 189000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  output logic       rx_inhibit,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RELEASE, S_SHIFT, S_ACK, S_WAIT_IDLE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [20:0] tmr, tmr_nxt;
  logic [3:0]  edge_cnt, edge_nxt;
  logic [9:0]  frame_q, frame_nxt;
  logic        clk_oe_q, clk_oe_nxt;
  logic        data_oe_q, data_oe_nxt;
  logic [1:0]  err_code_q, err_nxt;
  logic        clk_f, data_f, clk_f_d;
  logic        fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .line_in(ps2_clk_in), .line_f(clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst(rst), .line_in(ps2_data_in), .line_f(data_f)
  );

  assign fall = clk_f_d & ~clk_f;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      tmr        <= '0;
      edge_cnt   <= '0;
      frame_q    <= '1;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      err_code_q <= 2'b00;
      clk_f_d    <= 1'b1;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      edge_cnt   <= edge_nxt;
      frame_q    <= frame_nxt;
      clk_oe_q   <= clk_oe_nxt;
      data_oe_q  <= data_oe_nxt;
      err_code_q <= err_nxt;
      clk_f_d    <= clk_f;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = (tmr == 21'd0) ? tmr : tmr - 21'd1;
    edge_nxt    = edge_cnt;
    frame_nxt   = frame_q;
    clk_oe_nxt  = 1'b0;
    data_oe_nxt = 1'b0;
    err_nxt     = err_code_q;
    tx_done     = 1'b0;
    tx_err      = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          frame_nxt   = {1'b1, ~^tx_data, tx_data};
          err_nxt     = 2'b00;
          tmr_nxt     = 21'(INHIBIT_CYCLES - 1);
          clk_oe_nxt  = 1'b1;
          data_oe_nxt = (INHIBIT_CYCLES == 1);
          state_nxt   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (tmr == 21'd0) begin
          tmr_nxt     = 21'(START_TIMEOUT - 1);
          data_oe_nxt = 1'b1;
          state_nxt   = S_RELEASE;
        end else begin
          clk_oe_nxt  = 1'b1;
          data_oe_nxt = (tmr == 21'd1);
        end
      end
      S_RELEASE: begin
        if (fall) begin
          data_oe_nxt = ~frame_q[0];
          frame_nxt   = {1'b1, frame_q[9:1]};
          edge_nxt    = 4'd1;
          tmr_nxt     = 21'(XFER_TIMEOUT - 1);
          state_nxt   = S_SHIFT;
        end else if (tmr == 21'd0) begin
          err_nxt   = 2'b01;
          state_nxt = S_ERR;
        end else begin
          data_oe_nxt = 1'b1;
        end
      end
      S_SHIFT: begin
        // Edge 10 shifts out the stop bit, which releases the data line.
        if (fall) begin
          data_oe_nxt = ~frame_q[0];
          frame_nxt   = {1'b1, frame_q[9:1]};
          edge_nxt    = edge_cnt + 4'd1;
          if (edge_cnt == 4'd9) state_nxt = S_ACK;
        end else if (tmr == 21'd0) begin
          err_nxt   = 2'b10;
          state_nxt = S_ERR;
        end else begin
          data_oe_nxt = data_oe_q;
        end
      end
      S_ACK: begin
        if (fall) begin
          err_nxt   = data_f ? 2'b11 : 2'b00;
          state_nxt = S_WAIT_IDLE;
        end else if (tmr == 21'd0) begin
          err_nxt   = 2'b10;
          state_nxt = S_ERR;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_f && data_f) begin
          tx_done   = 1'b1;
          tx_err    = (err_code_q == 2'b11);
          state_nxt = S_IDLE;
        end else if (tmr == 21'd0) begin
          err_nxt   = 2'b10;
          state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        tx_done   = 1'b1;
        tx_err    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign tx_ready    = (state == S_IDLE);
  assign rx_inhibit  = (state != S_IDLE) | tx_valid;
  assign err_code    = err_code_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model on wired-AND lines exercises ACK,
// NACK, both timeouts, mid-transfer reset, clock glitch rejection and busy requests.
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int ST  = 400;
  localparam int XT  = 2000;
  localparam int FL  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, rx_inhibit;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_edge1 = 0;
  int done_cnt = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT), .FILTER_LEN(FL)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .err_code(err_code),
    .rx_inhibit(rx_inhibit), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_done) done_cnt++;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while ((ps2_clk_oe || !ps2_data_oe) && n < 200) begin tick(1); n++; end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!tx_done && n < limit) begin tick(1); n++; end
  endtask

  // Device model: 40-cycle half periods, samples host data at each rising edge.
  task automatic dev_xfer(input int edges, input logic nack, input int glitch_pulse,
                          output logic [10:0] bits);
    bits = '1;
    for (int e = 1; e <= edges && e <= 10; e++) begin
      if (e == 1) t_edge1 = cyc;
      dev_clk = 1'b0; tick(40);
      dev_clk = 1'b1; bits[e-1] = ps2_data_in;
      if (e == glitch_pulse) begin
        tick(20); dev_clk = 1'b0; tick(1); dev_clk = 1'b1; tick(19);
      end else begin
        tick(40);
      end
    end
    if (edges >= 11) begin
      dev_data = nack; tick(20);
      dev_clk = 1'b0; tick(40);
      dev_clk = 1'b1; dev_data = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; tick(3);
    vectors++;
    if ({tx_ready, tx_done, tx_err, err_code, rx_inhibit, ps2_clk_oe, ps2_data_oe} !== 8'b1000_0000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 10000000",
               {tx_ready, tx_done, tx_err, err_code, rx_inhibit, ps2_clk_oe, ps2_data_oe});
    end
    rst = 1'b1; tick(5);
  endtask

  task automatic test_ack_f4;
    int n; logic bad; logic [10:0] bits;
    send(8'hF4);
    vectors++;
    if ({tx_ready, ps2_clk_oe, rx_inhibit} !== 3'b011) begin
      miscompares++; $display("FAIL accept_f4: ready/clk_oe/inhibit got %b want 011", {tx_ready, ps2_clk_oe, rx_inhibit});
    end
    n = 0; bad = 1'b0;
    while (ps2_clk_oe && n < 100) begin
      if (ps2_data_oe !== 1'(n == INH - 1)) bad = 1'b1;
      n++; tick(1);
    end
    vectors++;
    if (n != INH) begin miscompares++; $display("FAIL inhibit_len: got %0d want %0d", n, INH); end
    vectors++;
    if (bad !== 1'b0 || ps2_data_oe !== 1'b1) begin
      miscompares++; $display("FAIL start_bit: data_oe timing bad=%b data_oe=%b want 0/1", bad, ps2_data_oe);
    end
    tick(10);
    dev_xfer(11, 1'b0, 0, bits);
    vectors++;
    if (bits[9:0] !== {1'b1, 1'b0, 8'hF4}) begin
      miscompares++; $display("FAIL frame_f4: got %h want %h", bits[9:0], {2'b10, 8'hF4});
    end
    wait_done(50, n);
    vectors++;
    if (n >= 50 || tx_err !== 1'b0 || err_code !== 2'b00) begin
      miscompares++; $display("FAIL done_f4: wait=%0d err=%b code=%b want done, 0, 00", n, tx_err, err_code);
    end
    tick(1);
    vectors++;
    if (tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      miscompares++; $display("FAIL ready_f4: ready=%b done=%b want 1/0", tx_ready, tx_done);
    end
  endtask

  task automatic test_nack_ff;
    int n; logic [10:0] bits;
    send(8'hFF);
    wait_release(n);
    tick(10);
    dev_xfer(11, 1'b1, 0, bits);
    vectors++;
    if (bits[9:0] !== {1'b1, 1'b1, 8'hFF}) begin
      miscompares++; $display("FAIL frame_ff: got %h want %h", bits[9:0], {2'b11, 8'hFF});
    end
    wait_done(50, n);
    vectors++;
    if (n >= 50 || tx_err !== 1'b1 || err_code !== 2'b11) begin
      miscompares++; $display("FAIL nack_ff: wait=%0d err=%b code=%b want done, 1, 11", n, tx_err, err_code);
    end
    tick(5);
  endtask

  task automatic test_start_timeout;
    int n;
    send(8'h00);
    wait_release(n);
    wait_done(600, n);
    vectors++;
    if (n < ST - 2 || n > ST + 2) begin
      miscompares++; $display("FAIL start_timeout_len: got %0d want %0d", n, ST);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_err, err_code} !== 5'b00101) begin
      miscompares++; $display("FAIL start_timeout: oe/err/code got %b want 00101", {ps2_clk_oe, ps2_data_oe, tx_err, err_code});
    end
    tick(1);
    vectors++;
    if (tx_ready !== 1'b1) begin miscompares++; $display("FAIL start_timeout_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_xfer_timeout;
    int n; int el; logic [10:0] bits;
    send(8'h3C);
    wait_release(n);
    tick(10);
    dev_xfer(5, 1'b0, 0, bits);
    vectors++;
    if (bits[4:0] !== 5'b11100) begin
      miscompares++; $display("FAIL partial_bits: got %b want 11100", bits[4:0]);
    end
    wait_done(3000, n);
    el = cyc - t_edge1;
    vectors++;
    if (n >= 3000 || el < XT || el > XT + 10) begin
      miscompares++; $display("FAIL xfer_timeout_len: got %0d want %0d..%0d", el, XT, XT + 10);
    end
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe, tx_err, err_code} !== 5'b00110) begin
      miscompares++; $display("FAIL xfer_timeout: oe/err/code got %b want 00110", {ps2_clk_oe, ps2_data_oe, tx_err, err_code});
    end
    tick(5);
  endtask

  task automatic test_reset_mid;
    int n; logic [10:0] bits;
    send(8'h00);
    wait_release(n);
    tick(10);
    dev_xfer(5, 1'b0, 0, bits);
    dev_clk = 1'b0; tick(20);
    vectors++;
    if (ps2_data_oe !== 1'b1) begin miscompares++; $display("FAIL pre_reset_drive: got %b want 1", ps2_data_oe); end
    rst = 1'b0; #1;
    vectors++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      miscompares++; $display("FAIL async_reset_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe});
    end
    vectors++;
    if ({tx_ready, tx_done, tx_err, err_code, rx_inhibit} !== 6'b100000) begin
      miscompares++; $display("FAIL async_reset_outs: got %b want 100000", {tx_ready, tx_done, tx_err, err_code, rx_inhibit});
    end
    dev_clk = 1'b1; tick(2); rst = 1'b1; tick(10);
    send(8'hF4);
    wait_release(n);
    tick(10);
    dev_xfer(11, 1'b0, 0, bits);
    wait_done(50, n);
    vectors++;
    if (n >= 50 || bits[9:0] !== {2'b10, 8'hF4} || tx_err !== 1'b0 || err_code !== 2'b00) begin
      miscompares++; $display("FAIL after_reset_f4: wait=%0d frame=%h err=%b code=%b want <50, 2f4, 0, 00",
                              n, bits[9:0], tx_err, err_code);
    end
    tick(5);
  endtask

  task automatic test_glitch_busy;
    int n; int d0; logic [10:0] bits;
    d0 = done_cnt;
    send(8'hA5);
    tick(3);
    tx_data = 8'h12; tx_valid = 1'b1; tick(1); tx_valid = 1'b0;
    wait_release(n);
    tick(10);
    dev_xfer(11, 1'b0, 3, bits);
    wait_done(50, n);
    vectors++;
    if (bits[9:0] !== {1'b1, 1'b1, 8'hA5}) begin
      miscompares++; $display("FAIL glitch_frame: got %h want %h", bits[9:0], {2'b11, 8'hA5});
    end
    vectors++;
    if (n >= 50 || tx_err !== 1'b0 || err_code !== 2'b00) begin
      miscompares++; $display("FAIL glitch_done: wait=%0d err=%b code=%b want done, 0, 00", n, tx_err, err_code);
    end
    tick(100);
    vectors++;
    if (done_cnt - d0 != 1 || ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin
      miscompares++; $display("FAIL busy_ignored: done pulses %0d clk_oe %b ready %b want 1, 0, 1",
                              done_cnt - d0, ps2_clk_oe, tx_ready);
    end
  endtask

  initial begin
    test_reset();
    test_ack_f4();
    test_nack_ff();
    test_start_timeout();
    test_xfer_timeout();
    test_reset_mid();
    test_glitch_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter: sends one command byte (e.g. 0xFF reset, 0xF4 enable data reporting) from the FPGA to the mouse on the shared PS2Clk/PS2Data lines. It complements the mouse receive path and runs in the 94.5 MHz mouse clock domain. It drives the lines only as open-drain pull-downs; tristate buffers sit at top level.

## Interface
Parameters:
- INHIBIT_CYCLES, 9450: clock-low inhibit time (100 µs at 94.5 MHz)
- START_TIMEOUT, 1417500: max wait for first device clock edge (15 ms)
- XFER_TIMEOUT, 189000: max time from first edge to ACK edge (2 ms)
- FILTER_LEN, 8: consecutive equal samples needed to accept a new line level

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- tx_data  in  8  command byte
- tx_valid  in  1  request; accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- tx_done  out  1  one-cycle pulse at end of every accepted transfer (success or error)
- tx_err  out  1  one-cycle pulse coincident with tx_done on failure
- err_code  out  2  00 ok, 01 start timeout, 10 transfer timeout, 11 NACK; valid from tx_done until next accept
- rx_inhibit  out  1  high whenever not IDLE; the receive path discards frames while high
- ps2_clk_in  in  1  raw PS2Clk level
- ps2_data_in  in  1  raw PS2Data level
- ps2_clk_oe  out  1  1 = pull PS2Clk low
- ps2_data_oe  out  1  1 = pull PS2Data low

## Operation
- Input conditioning: each raw line goes through a 2-FF synchronizer, then a FILTER_LEN glitch filter (counter resets on mismatch). Filtered values reset to 1. A device falling edge is the filtered clock going 1→0.
- Frame: 11 bits after start: d0..d7 (LSB first), odd parity (~^tx_data), stop (1); then the device ACK bit.
- FSM states:
  - IDLE: both oe=0, tx_ready=1. On accept: latch byte, compute parity, clear err_code, go INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. In the last cycle, also set data_oe=1 (start bit), then go RELEASE.
  - RELEASE: clk_oe=0, data_oe=1, start timer. Go SHIFT on the first falling edge. After START_TIMEOUT cycles with no edge, go ERR (01).
  - SHIFT: on falling edges 1..10, data_oe = ~bit(d0..d7, parity, stop). Edge 10 releases data (data_oe=0), then go ACK.
  - ACK: on the next falling edge (edge 11), sample filtered data: 0 → success, 1 → NACK (11). Go WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clock and data are both 1. Then pulse tx_done (plus tx_err if NACK) and go IDLE.
  - ERR: both oe=0. Pulse tx_done and tx_err with err_code, then go IDLE.
- Transfer timer starts at edge 1 and covers SHIFT, ACK and WAIT_IDLE. Reaching XFER_TIMEOUT from any of these states goes to ERR (10).
- A device frame in progress at accept is overridden by the inhibit. rx_inhibit is high from the accept cycle onward.
- tx_valid outside IDLE is ignored; it is not queued.

## Timing
- Reset values (any time, including mid-transfer, asynchronous): state IDLE, clk_oe=0, data_oe=0, tx_ready=1, tx_done=0, tx_err=0, err_code=00, rx_inhibit=0, filtered lines=1.
- Accept at cycle N: tx_ready=0 and clk_oe=1 from cycle N+1.
- data_oe rises in the last inhibit cycle. clk_oe falls the following cycle.
- Filter latency: 2 + FILTER_LEN cycles from a raw line change to the filtered change.
- data_oe updates one cycle after the detected falling edge. This is far inside the ≥30 µs PS/2 low phase.
- tx_done is asserted for exactly one cycle. tx_ready returns the cycle after tx_done, and a new accept is legal then.
- Counters: timeout counters are 21 bits and saturate; they do not wrap.

## Test plan
Simulations use INHIBIT_CYCLES=20, START_TIMEOUT=400, XFER_TIMEOUT=2000, FILTER_LEN=2, and a device model with 40-cycle half-periods.
- Send 0xF4; model ACKs → model captures d=0xF4, parity=0, stop=1; clk_oe high exactly 20 cycles; tx_done pulse, tx_err=0, err_code=00.
- Send 0xFF; model NACKs (data high at edge 11) → captured 0xFF, parity=1; tx_done+tx_err, err_code=11.
- Send 0x00; model never clocks → both oe=0 at ~400 cycles after release; err_code=01; tx_ready=1 next cycle.
- Model stops after 5 edges → err_code=10 at 2000 cycles after edge 1; lines released.
- Assert rst during edge 6 → clk_oe=data_oe=0 immediately (same timestep, asynchronous); outputs at reset values; next 0xF4 completes normally.
- Inject a 1-cycle raw clock glitch mid-bit → no bit advance; byte received correctly. tx_valid pulsed while busy → ignored, exactly one tx_done.
